// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// word size used for DMA address stepping, and the default top of memory.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int          WORD_BYTES  = 4;
    localparam logic [31:0] DEF_MEM_TOP = 32'h0004_AFFF;

endpackage

// File: rtl/dma_addr_gen.sv
// DMA burst address generator.
// Holds the current beat address and the remaining-beat down-counter, and
// flags the last beat and beats that fall above the top of memory.
//   clk, rst      : clock, synchronous active-high reset
//   load          : burst accepted; capture base and len
//   base, len     : burst start byte address and beat count
//   step          : a beat was issued this cycle; advance
//   addr          : address of the next beat
//   remaining     : beats still to issue
//   last_beat     : the next beat is the final one
//   out_of_range  : addr lies above MEM_TOP
module dma_addr_gen
    import dmem_arb_pkg::*;
#(
    parameter int             N       = 32,
    parameter int             LEN_W   = 5,
    parameter logic [N-1:0]   MEM_TOP = N'(DEF_MEM_TOP)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [N-1:0]     base,
    input  logic [LEN_W-1:0] len,
    input  logic             step,
    output logic [N-1:0]     addr,
    output logic [LEN_W-1:0] remaining,
    output logic             last_beat,
    output logic             out_of_range
);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
        end else if (load) begin
            addr      <= base;
            remaining <= len;
        end else if (step) begin
            // Wraps modulo 2^N by construction.
            addr      <= addr + N'(WORD_BYTES);
            remaining <= remaining - LEN_W'(1);
        end
    end

    assign last_beat    = (remaining == LEN_W'(1));
    assign out_of_range = (addr > MEM_TOP);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the CPU Memory stage and a DMA burst engine.
// CPU has priority; a DMA burst may hold off a pending CPU access for at most
// CPU_WAIT_MAX beats before the CPU is forced a slot.
//   clk, rst                         : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata, cpu_rdata : M-stage access and load data
//   cpu_stall                        : CPU access not granted this cycle
//   dma_req/we/base/len/wdata        : burst request (sampled in IDLE)
//   dma_beat, dma_rdata              : beat issued / read data for the beat
//   dma_done, dma_err                : end-of-burst pulse, sticky range error
//   mem_addr/wdata/we, mem_rdata     : external memory port
//
// state | meaning
// IDLE  | no burst active; CPU served, or a new burst is accepted
// BURST | issuing DMA beats, yielding to the CPU when its wait bound is hit
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int           N            = 32,
    parameter int           LEN_W        = 5,
    parameter int           CPU_WAIT_MAX = 4,
    parameter logic [N-1:0] MEM_TOP      = N'(DEF_MEM_TOP)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [N-1:0]     cpu_addr,
    input  logic [N-1:0]     cpu_wdata,
    output logic [N-1:0]     cpu_rdata,
    output logic             cpu_stall,
    input  logic             dma_req,
    input  logic             dma_we,
    input  logic [N-1:0]     dma_base,
    input  logic [LEN_W-1:0] dma_len,
    input  logic [N-1:0]     dma_wdata,
    output logic             dma_beat,
    output logic [N-1:0]     dma_rdata,
    output logic             dma_done,
    output logic             dma_err,
    output logic [N-1:0]     mem_addr,
    output logic [N-1:0]     mem_wdata,
    output logic             mem_we,
    input  logic [N-1:0]     mem_rdata
);

    localparam int WAIT_W = $clog2(CPU_WAIT_MAX + 1);

    arb_state_t        state, next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              dma_we_lat;
    logic              cpu_grant;
    logic              accept;
    logic [N-1:0]      beat_addr;
    logic [LEN_W-1:0]  remaining;
    logic              last_beat;
    logic              out_of_range;

    dma_addr_gen #(
        .N       (N),
        .LEN_W   (LEN_W),
        .MEM_TOP (MEM_TOP)
    ) u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .load         (accept),
        .base         (dma_base),
        .len          (dma_len),
        .step         (dma_beat),
        .addr         (beat_addr),
        .remaining    (remaining),
        .last_beat    (last_beat),
        .out_of_range (out_of_range)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            dma_we_lat <= 1'b0;
            dma_done   <= 1'b0;
            dma_err    <= 1'b0;
        end else begin
            state    <= next_state;
            dma_done <= (dma_beat && last_beat) || (accept && (dma_len == '0));

            if (accept) begin
                dma_we_lat <= dma_we;
                dma_err    <= 1'b0;
            end else if (dma_beat && out_of_range) begin
                dma_err    <= 1'b1;
            end

            // Counts consecutive beats that kept a pending CPU waiting.
            if (dma_beat && cpu_req) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        next_state = state;
        cpu_grant  = 1'b0;
        accept     = 1'b0;
        dma_beat   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_req) begin
                    cpu_grant = 1'b1;
                end else if (dma_req) begin
                    accept     = 1'b1;
                    next_state = (dma_len == '0) ? IDLE : BURST;
                end
            end
            BURST: begin
                if (cpu_req && (wait_cnt == WAIT_W'(CPU_WAIT_MAX))) begin
                    cpu_grant = 1'b1;
                end else begin
                    dma_beat = 1'b1;
                    if (last_beat) begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (cpu_grant) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
        end else if (dma_beat) begin
            mem_addr  = beat_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_we_lat && !out_of_range;
        end
    end

    assign cpu_stall = cpu_req && !cpu_grant;
    assign cpu_rdata = mem_rdata;
    assign dma_rdata = (dma_beat && !dma_we_lat && !out_of_range) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dma_req, dma_we;
    logic [31:0] dma_base, dma_wdata, dma_rdata;
    logic [4:0]  dma_len;
    logic        dma_beat, dma_done, dma_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    int tests  = 0;
    int failed = 0;

    // Memory model: read data is a fixed function of the address.
    assign mem_rdata = mem_addr ^ 32'h5A5A_0000;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_base  (dma_base),
        .dma_len   (dma_len),
        .dma_wdata (dma_wdata),
        .dma_beat  (dma_beat),
        .dma_rdata (dma_rdata),
        .dma_done  (dma_done),
        .dma_err   (dma_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are changed right after.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_base = 0; dma_len = 0; dma_wdata = 0;

        // Reset state
        cyc(); cyc(); settle();
        chk("rst_done", 32'(dma_done), 0);
        chk("rst_err", 32'(dma_err), 0);
        chk("rst_beat", 32'(dma_beat), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_stall", 32'(cpu_stall), 0);
        rst = 1'b0;

        // CPU only store
        cyc();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h100; cpu_wdata = 32'hDEADBEEF;
        settle();
        chk("cpu_mem_we", 32'(mem_we), 1);
        chk("cpu_mem_addr", mem_addr, 32'h100);
        chk("cpu_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("cpu_stall", 32'(cpu_stall), 0);
        chk("cpu_no_beat", 32'(dma_beat), 0);
        chk("cpu_rdata", cpu_rdata, 32'h5A5A_0100);

        // CPU beats a simultaneous DMA request in IDLE
        cyc();
        cpu_we = 0; dma_req = 1; dma_base = 32'h400; dma_len = 5'd2;
        settle();
        chk("prio_stall", 32'(cpu_stall), 0);
        chk("prio_addr", mem_addr, 32'h100);
        cyc();
        cpu_req = 0; dma_req = 0;
        settle();
        chk("prio_not_accepted", 32'(dma_beat), 0);

        // DMA read, 4 beats
        cyc();
        dma_req = 1; dma_we = 0; dma_base = 32'h200; dma_len = 5'd4;
        settle();
        chk("rd_accept_beat", 32'(dma_beat), 0);
        chk("rd_accept_we", 32'(mem_we), 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            dma_req = 0; dma_base = 32'h999; dma_len = 5'd7; dma_we = 1;
            settle();
            chk("rd_beat", 32'(dma_beat), 1);
            chk("rd_addr", mem_addr, 32'h200 + 32'(4 * i));
            chk("rd_we", 32'(mem_we), 0);
            chk("rd_data", dma_rdata, 32'h5A5A_0200 + 32'(4 * i));
            chk("rd_no_done", 32'(dma_done), 0);
        end
        cyc(); settle();
        chk("rd_done", 32'(dma_done), 1);
        chk("rd_done_no_beat", 32'(dma_beat), 0);
        cyc(); settle();
        chk("rd_done_pulse", 32'(dma_done), 0);

        // Contention: 10-beat write, CPU pending from beat 2
        dma_req = 1; dma_we = 1; dma_base = 32'h1000; dma_len = 5'd10;
        settle();
        cyc();
        dma_req = 0; dma_wdata = 32'hC0DE_0001;
        settle();
        chk("ct_b1_addr", mem_addr, 32'h1000);
        chk("ct_b1_we", 32'(mem_we), 1);
        chk("ct_b1_wdata", mem_wdata, 32'hC0DE_0001);
        chk("ct_b1_stall", 32'(cpu_stall), 0);
        for (int k = 2; k <= 5; k++) begin
            cyc();
            cpu_req = 1; cpu_we = 0; cpu_addr = 32'h300;
            dma_wdata = 32'hC0DE_0000 + 32'(k);
            settle();
            chk("ct_stall", 32'(cpu_stall), 1);
            chk("ct_beat", 32'(dma_beat), 1);
            chk("ct_addr", mem_addr, 32'h1000 + 32'(4 * (k - 1)));
            chk("ct_wdata", mem_wdata, 32'hC0DE_0000 + 32'(k));
        end
        cyc(); settle();
        chk("ct_grant_stall", 32'(cpu_stall), 0);
        chk("ct_grant_beat", 32'(dma_beat), 0);
        chk("ct_grant_addr", mem_addr, 32'h300);
        chk("ct_grant_we", 32'(mem_we), 0);
        for (int k = 6; k <= 10; k++) begin
            cyc();
            cpu_req = 0;
            dma_wdata = 32'hC0DE_0000 + 32'(k);
            settle();
            chk("ct_resume_beat", 32'(dma_beat), 1);
            chk("ct_resume_addr", mem_addr, 32'h1000 + 32'(4 * (k - 1)));
            chk("ct_resume_we", 32'(mem_we), 1);
        end
        cyc(); settle();
        chk("ct_done", 32'(dma_done), 1);

        // Range / error: last beat above top of memory
        dma_req = 1; dma_we = 1; dma_base = 32'h4AFF8; dma_len = 5'd3;
        settle();
        cyc();
        dma_req = 0;
        settle();
        chk("rg_b1_addr", mem_addr, 32'h4AFF8);
        chk("rg_b1_we", 32'(mem_we), 1);
        cyc(); settle();
        chk("rg_b2_addr", mem_addr, 32'h4AFFC);
        chk("rg_b2_we", 32'(mem_we), 1);
        chk("rg_b2_err", 32'(dma_err), 0);
        cyc(); settle();
        chk("rg_b3_addr", mem_addr, 32'h4B000);
        chk("rg_b3_beat", 32'(dma_beat), 1);
        chk("rg_b3_we", 32'(mem_we), 0);
        cyc(); settle();
        chk("rg_done", 32'(dma_done), 1);
        chk("rg_err", 32'(dma_err), 1);
        cyc(); settle();
        chk("rg_err_sticky", 32'(dma_err), 1);

        // Wrap: read burst crossing 2^32
        dma_req = 1; dma_we = 0; dma_base = 32'hFFFF_FFFC; dma_len = 5'd2;
        settle();
        chk("wr_accept_err_held", 32'(dma_err), 1);
        cyc();
        dma_req = 0;
        settle();
        chk("wr_err_cleared", 32'(dma_err), 0);
        chk("wr_b1_addr", mem_addr, 32'hFFFF_FFFC);
        chk("wr_b1_rdata_oor", dma_rdata, 0);
        cyc(); settle();
        chk("wr_b2_addr", mem_addr, 32'h0);
        chk("wr_b2_rdata", dma_rdata, 32'h5A5A_0000);
        // Done cycle: accept a zero-length burst right away
        cyc();
        dma_req = 1; dma_len = 5'd0; dma_base = 32'h800;
        settle();
        chk("wr_done", 32'(dma_done), 1);
        chk("wr_err_set", 32'(dma_err), 1);
        cyc();
        dma_req = 0;
        settle();
        chk("l0_done", 32'(dma_done), 1);
        chk("l0_no_beat", 32'(dma_beat), 0);
        chk("l0_err_cleared", 32'(dma_err), 0);
        cyc(); settle();
        chk("l0_done_pulse", 32'(dma_done), 0);
        chk("l0_still_idle", 32'(dma_beat), 0);

        // Reset mid-burst on beat 3 of 8
        dma_req = 1; dma_we = 1; dma_base = 32'h2000; dma_len = 5'd8;
        settle();
        cyc();
        dma_req = 0;
        cyc();
        rst = 1;
        cyc();
        rst = 0;
        settle();
        chk("mr_beat", 32'(dma_beat), 0);
        chk("mr_we", 32'(mem_we), 0);
        chk("mr_done", 32'(dma_done), 0);
        chk("mr_err", 32'(dma_err), 0);
        for (int i = 0; i < 8; i++) begin
            cyc(); settle();
            chk("mr_no_done", 32'(dma_done), 0);
            chk("mr_no_beat", 32'(dma_beat), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
